// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and frame geometry.
// Imported by the transmit controller, the baud generator and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_BIT9  = 3'd4,
      ST_STOP  = 3'd5
   } uart_tx_state_t;

   localparam int UART_DATA_BITS    = 8;
   // start + data + stop, and the same with the optional 9th bit
   localparam int UART_FRAME_BITS   = UART_DATA_BITS + 2;
   localparam int UART_FRAME_BITS_9 = UART_DATA_BITS + 3;
   localparam logic [2:0] UART_LAST_BIT = 3'(UART_DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// CPU/SFR, baud-tick and pin signals of the USART transmitter.
// The master side is the SFR/interrupt logic and baud generator; the slave is the controller.
interface uart_tx_ctrl_if;

   logic                                spen;
   logic                                txen;
   logic                                tx9;
   logic                                tx9d;
   logic                                uart_tx_shift_en;
   logic                                txreg_wr_en;
   logic [uart_pkg::UART_DATA_BITS-1:0] txreg_in;
   logic                                txif;
   logic                                trmt;
   logic                                tx_pin;
   logic                                tx_oe;

   modport master (
      output spen, txen, tx9, tx9d, uart_tx_shift_en, txreg_wr_en, txreg_in,
      input  txif, trmt, tx_pin, tx_oe
   );

   modport slave (
      input  spen, txen, tx9, tx9d, uart_tx_shift_en, txreg_wr_en, txreg_in,
      output txif, trmt, tx_pin, tx_oe
   );

endinterface

// File: rtl/uart_tx_shifter.sv
// Transmit shift register (TSR) with data-bit counter.
// Load wins over shift; the counter saturates on the last data bit.
module uart_tx_shifter
   import uart_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_i,
   input  logic                      shift_i,
   input  logic                      cnt_clr_i,
   input  logic [UART_DATA_BITS-1:0] data_i,
   output logic                      lsb_o,
   output logic                      nxt_o,
   output logic                      done_o
);

   logic [UART_DATA_BITS-1:0] tsr_q, tsr_d;
   logic [2:0]                cnt_q, cnt_d;

   assign lsb_o  = tsr_q[0];
   assign nxt_o  = tsr_q[1];
   assign done_o = (cnt_q == UART_LAST_BIT);

   always_comb begin
      tsr_d = tsr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         tsr_d = data_i;
         cnt_d = '0;
      end else if (shift_i) begin
         tsr_d = tsr_q >> 1;
         cnt_d = done_o ? cnt_q : cnt_q + 3'd1;
      end else if (cnt_clr_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tsr_q <= '0;
         cnt_q <= '0;
      end else begin
         tsr_q <= tsr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// PIC16F-style USART transmit controller: TXREG buffer, frame sequencing on
// baud ticks, TXIF/TRMT status and the TX pin.
module uart_tx_ctrl
   import uart_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   uart_tx_ctrl_if.slave  bus
);

   uart_tx_state_t            state_q, state_d;
   logic [UART_DATA_BITS-1:0] buf_q, buf_d;
   logic                      full_q, full_d;
   logic                      pin_q, pin_d;
   logic                      en_q;
   logic                      bit9_q, bit9_d;
   logic                      b9en_q, b9en_d;

   logic en, tick, kill;
   logic xfer, shift, cnt_clr;
   logic tsr_lsb, tsr_nxt, cnt_done;

   assign en   = bus.spen & bus.txen;
   assign tick = bus.uart_tx_shift_en;
   // Disable forces idle on the edge enable drops (or if somehow busy while
   // disabled); a buffer written while already disabled is kept for later.
   assign kill = ~en & (en_q | (state_q != ST_IDLE));

   assign bus.txif   = ~full_q;
   assign bus.trmt   = (state_q == ST_IDLE);
   assign bus.tx_pin = pin_q;
   assign bus.tx_oe  = bus.spen;

   uart_tx_shifter u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load_i    (xfer),
      .shift_i   (shift),
      .cnt_clr_i (cnt_clr),
      .data_i    (buf_q),
      .lsb_o     (tsr_lsb),
      .nxt_o     (tsr_nxt),
      .done_o    (cnt_done)
   );

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      full_d  = full_q;
      pin_d   = pin_q;
      bit9_d  = bit9_q;
      b9en_d  = b9en_q;
      xfer    = 1'b0;
      shift   = 1'b0;
      cnt_clr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en && full_q) begin
               xfer    = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tick) begin
               state_d = ST_START;
               pin_d   = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               pin_d   = tsr_lsb;
               cnt_clr = 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (!cnt_done) begin
                  shift = 1'b1;
                  pin_d = tsr_nxt;
               end else if (b9en_q) begin
                  state_d = ST_BIT9;
                  pin_d   = bit9_q;
               end else begin
                  state_d = ST_STOP;
                  pin_d   = 1'b1;
               end
            end
         end
         ST_BIT9: begin
            if (tick) begin
               state_d = ST_STOP;
               pin_d   = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               // Back-to-back frames: next start bit follows the stop bit directly.
               if (en && full_q) begin
                  xfer    = 1'b1;
                  state_d = ST_START;
                  pin_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  pin_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            pin_d   = 1'b1;
         end
      endcase

      if (xfer) begin
         full_d = 1'b0;
         bit9_d = bus.tx9d;
         b9en_d = bus.tx9;
      end

      // A write in the transfer cycle refills the buffer after TSR took the old byte.
      if (bus.txreg_wr_en) begin
         buf_d  = bus.txreg_in;
         full_d = 1'b1;
      end

      if (kill) begin
         state_d = ST_IDLE;
         pin_d   = 1'b1;
         full_d  = 1'b0;
         xfer    = 1'b0;
         shift   = 1'b0;
         cnt_clr = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         full_q  <= 1'b0;
         pin_q   <= 1'b1;
         en_q    <= 1'b0;
         b9en_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         pin_q   <= pin_d;
         en_q    <= en;
         b9en_q  <= b9en_d;
      end
   end

   // Payload registers carry no reset; full_q and b9en_q qualify them.
   always_ff @(posedge clk) begin
      buf_q  <= buf_d;
      bit9_q <= bit9_d;
   end

endmodule
